hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Central pipeline controller for the 5-stage pipelined core.
- Generates the enable (stall) and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates the operand forwarding selects for the execute stage.
- Sequences multi-cycle data-memory accesses through a wait/timeout FSM; freezes the pipeline while memory is not ready.

Parameters:
- REG_ADDR_W, 5, register-file address width
- TIMEOUT, 256, max MEM_WAIT cycles before error; min 2
- CNT_W, 32, width of optional performance counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D  in  REG_ADDR_W  source reg 1 in decode
- Rs2D  in  REG_ADDR_W  source reg 2 in decode
- Rs1E  in  REG_ADDR_W  source reg 1 in execute
- Rs2E  in  REG_ADDR_W  source reg 2 in execute
- RdE  in  REG_ADDR_W  destination reg in execute
- MemReadE  in  1  execute-stage instruction is a load
- PCSrcE  in  1  branch taken / jump resolved in execute
- RdM  in  REG_ADDR_W  destination reg in memory stage
- RegWriteM  in  1  memory-stage instruction writes a register
- MemReqM  in  1  memory stage issuing a data access
- MemReadyM  in  1  data memory completes the access this cycle
- RdW  in  REG_ADDR_W  destination reg in writeback
- RegWriteW  in  1  writeback-stage instruction writes a register
- StallF, StallD, StallE, StallM  out  1 each  hold the named stage register (pipeline register enable = ~Stall)
- FlushD, FlushE, FlushW  out  1 each  clear the named stage register (flush overrides enable)
- ForwardAE, ForwardBE  out  2 each  operand select: 00 = register file, 01 = W result, 10 = M ALU result
- mem_err  out  1  sticky memory-timeout error

Behaviour:
- State (FSM, wait_cnt) is registered. All stall/flush/forward outputs are combinational from the inputs and current state, so they take effect on the same edge.
- Reset (rst_n low, async):
  - State = RUN, wait_cnt = 0, mem_err = 0.
  - All Stall* = 0; FlushD, FlushE and FlushW = 1, so bubbles enter every register.
  - ForwardAE = ForwardBE = 00.
- Forwarding (ForwardAE shown; ForwardBE is identical using Rs2E):
  - 10 if RegWriteM and RdM == Rs1E and Rs1E != 0.
  - Else 01 if RegWriteW and RdW == Rs1E and Rs1E != 0.
  - Else 00.
  - M takes priority over W. x0 is never forwarded.
- Load-use: lwStall = MemReadE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
  - Gives StallF = StallD = 1 and FlushE = 1. Exactly 1 bubble.
- Control hazard: PCSrcE gives FlushD = FlushE = 1, killing 2 wrong-path instructions.
  - If lwStall and PCSrcE occur together: FlushD = 1 and StallD = 1, and the flush wins. FlushE = 1.
- Memory stall: memStall = (state == MEM_WAIT or (state == RUN and MemReqM)) and not MemReadyM, or state == ERROR.
  - memStall gives StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - FlushD and FlushE are forced to 0, so the whole front end freezes and PCSrcE stays valid in E until release.
  - lwStall and PCSrcE are evaluated again after release.
- FSM:
  - RUN to MEM_WAIT: MemReqM and not MemReadyM. wait_cnt is set to 1.
  - MEM_WAIT to RUN: MemReadyM. wait_cnt is set to 0. The pipeline advances on that same edge (memStall = 0 in that cycle).
  - MEM_WAIT to ERROR: wait_cnt == TIMEOUT-1 and not MemReadyM. mem_err is set to 1.
  - MEM_WAIT otherwise: wait_cnt increments by 1.
  - ERROR holds the pipeline stalled. Only rst_n exits it.
  - MemReqM with MemReadyM in the same cycle while in RUN: zero-wait access, stay in RUN, no stall.
- Reset asserted mid-MEM_WAIT: return to RUN immediately. The pending access is abandoned; the memory side is reset by the same rst_n.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs perf_lw_stalls, perf_flushes and perf_mem_stalls, each CNT_W wide.
  - Counts cycles of lwStall (not masked by memStall), PCSrcE flush events, and memStall cycles.
  - Each counter saturates at all-ones and resets to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with random inputs -> FlushD/E/W = 1, all Stall* = 0, Forward* = 00. Release -> state RUN.
- Forward priority: Rs1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> 01. Set Rs1E = RdM = RdW = 0 -> 00.
- Load-use: MemReadE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly 1 cycle. Add PCSrcE = 1 in the same cycle -> FlushD = 1 as well.
- Memory wait: MemReqM = 1, MemReadyM low for 4 cycles then high -> StallF/D/E/M = 1 and FlushW = 1 for exactly 4 cycles; released on the 5th. PCSrcE held high throughout -> FlushD/E = 0 during the stall, then 1 in the release cycle.
- Timeout (TIMEOUT = 4): MemReqM = 1, MemReadyM never high -> mem_err rises after 4 stall cycles and stays high with the pipeline stalled. Pulse rst_n -> mem_err = 0, state RUN.
- Zero-wait: MemReqM = MemReadyM = 1 for 10 consecutive cycles -> no stall asserted. With HAZARD_PERF_EN, perf_mem_stalls stays 0.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward controller for the 5-stage core, with a
// wait/timeout FSM that freezes the pipeline during multi-cycle data accesses.
// Ports: clk, rst_n (async active-low); decode/execute/memory/writeback
//   register indices and control bits in; StallF/D/E/M, FlushD/E/W,
//   ForwardAE/BE (00 regfile, 01 W, 10 M) and sticky mem_err out.
// Optional: define HAZARD_PERF_EN to add saturating counters
//   perf_lw_stalls, perf_flushes, perf_mem_stalls (CNT_W bits each).

module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 256,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  MemReadE,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0]      perf_lw_stalls,
    output logic [CNT_W-1:0]      perf_flushes,
    output logic [CNT_W-1:0]      perf_mem_stalls,
`endif
    output logic                  mem_err
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    if (TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
        $error("hazard_unit: TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nx;
    logic            mem_err_nx;
    logic            lw_stall;
    logic            mem_stall;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            mem_err  <= mem_err_nx;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        mem_err_nx  = mem_err;
        unique case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == WC_LAST) begin
                    state_nx   = ERROR;
                    mem_err_nx = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            ERROR: begin
                state_nx = ERROR;
            end
            default: begin
                state_nx    = RUN;
                wait_cnt_nx = '0;
            end
        endcase
    end

    // ---------------- hazard detection ----------------
    assign lw_stall = MemReadE && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // The ready cycle of a wait is not a stall: the pipeline advances on
    // the same edge that returns the FSM to RUN.
    assign mem_stall = (((state == MEM_WAIT) || ((state == RUN) && MemReqM))
                        && !MemReadyM) || (state == ERROR);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything up to M; only W takes a bubble.  The branch
            // in E is kept so it resolves again after release.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    // ---------------- forwarding ----------------
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (RegWriteM && (RdM == rs))
                sel = 2'b10;
            else if (RegWriteW && (RdW == rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign ForwardAE = rst_n ? fwd_sel(Rs1E) : 2'b00;
    assign ForwardBE = rst_n ? fwd_sel(Rs2E) : 2'b00;

`ifdef HAZARD_PERF_EN
    // ---------------- performance counters ----------------
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lw_stalls  <= '0;
            perf_flushes    <= '0;
            perf_mem_stalls <= '0;
        end else begin
            if (lw_stall && perf_lw_stalls != CNT_MAX)
                perf_lw_stalls <= perf_lw_stalls + 1'b1;
            if (PCSrcE && !mem_stall && perf_flushes != CNT_MAX)
                perf_flushes <= perf_flushes + 1'b1;
            if (mem_stall && perf_mem_stalls != CNT_MAX)
                perf_mem_stalls <= perf_mem_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard_unit.
// Two instances share inputs: u_dut (TIMEOUT=8) and u_to (TIMEOUT=4).

module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       MemReadE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;

    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_err;

    logic       t_StallF, t_StallD, t_StallE, t_StallM;
    logic       t_FlushD, t_FlushE, t_FlushW;
    logic [1:0] t_ForwardAE, t_ForwardBE;
    logic       t_mem_err;

`ifdef HAZARD_PERF_EN
    logic [31:0] p_lw, p_fl, p_ms, tp_lw, tp_fl, tp_ms;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_ADDR_W(5), .TIMEOUT(8), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
        .perf_lw_stalls(p_lw), .perf_flushes(p_fl), .perf_mem_stalls(p_ms),
`endif
        .mem_err(mem_err)
    );

    hazard_unit #(.REG_ADDR_W(5), .TIMEOUT(4), .CNT_W(32)) u_to (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .StallF(t_StallF), .StallD(t_StallD), .StallE(t_StallE),
        .StallM(t_StallM),
        .FlushD(t_FlushD), .FlushE(t_FlushE), .FlushW(t_FlushW),
        .ForwardAE(t_ForwardAE), .ForwardBE(t_ForwardBE),
`ifdef HAZARD_PERF_EN
        .perf_lw_stalls(tp_lw), .perf_flushes(tp_fl),
        .perf_mem_stalls(tp_ms),
`endif
        .mem_err(t_mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // stall/flush vector {F,D,E,M, fD,fE,fW}
    task automatic chk_sf(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, StallF, StallD, StallE, StallM,
                  FlushD, FlushE, FlushW}, {25'd0, exp});
    endtask

    task automatic chk_to(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, t_StallF, t_StallD, t_StallE, t_StallM,
                  t_FlushD, t_FlushE, t_FlushW}, {25'd0, exp});
    endtask

    task automatic idle();
        Rs1D = 5'd1; Rs2D = 5'd2; Rs1E = 5'd3; Rs2E = 5'd4;
        RdE = 5'd10; RdM = 5'd11; RdW = 5'd12;
        MemReadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // inputs change at negedge; combinational outputs checked 2ns later
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // ---- reset with random inputs ----
        for (int i = 0; i < 3; i++) begin
            step();
            {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM} = 30'($urandom);
            RdW = 5'($urandom);
            {MemReadE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW}
                = 6'($urandom);
            #2;
            chk_sf("rst_sf", 7'b0000_111);
            chk("rst_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
            chk("rst_err", {31'd0, mem_err}, 32'd0);
        end
        step();
        idle();
        rst_n = 1'b1;
        #2;
        chk_sf("run_idle", 7'b0000_000);

        // ---- forwarding priority ----
        step();
        Rs1E = 5; Rs2E = 5; RdM = 5; RdW = 5;
        RegWriteM = 1; RegWriteW = 1;
        #2;
        chk("fwd_m", {28'd0, ForwardAE, ForwardBE}, 32'b1010);
        step();
        RegWriteM = 0;
        #2;
        chk("fwd_w", {28'd0, ForwardAE, ForwardBE}, 32'b0101);
        step();
        RegWriteM = 1;
        Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0;
        #2;
        chk("fwd_x0", {28'd0, ForwardAE, ForwardBE}, 32'b0000);
        step();
        Rs1E = 9; Rs2E = 6; RdM = 9; RdW = 6;
        #2;
        chk("fwd_mix", {28'd0, ForwardAE, ForwardBE}, 32'b1001);

        // ---- load-use ----
        step();
        idle();
        MemReadE = 1; RdE = 7; Rs2D = 7;
        #2;
        chk_sf("lw_stall", 7'b1100_010);
        step();
        MemReadE = 0;
        #2;
        chk_sf("lw_done", 7'b0000_000);
        step();
        MemReadE = 1; RdE = 0; Rs1D = 0;
        #2;
        chk_sf("lw_x0", 7'b0000_000);
        step();
        RdE = 7; PCSrcE = 1;
        #2;
        chk_sf("lw_branch", 7'b1100_110);
        step();
        MemReadE = 0;
        #2;
        chk_sf("branch", 7'b0000_110);

        // ---- memory wait: 4 not-ready cycles, branch held in E ----
        step();
        idle();
        PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk_sf($sformatf("mw_stall%0d", i), 7'b1111_001);
            step();
        end
        MemReadyM = 1;
        #2;
        chk_sf("mw_release", 7'b0000_110);
        step();
        idle();
        #2;
        chk_sf("mw_after", 7'b0000_000);
        chk("mw_err", {31'd0, mem_err}, 32'd0);
        // TIMEOUT=4 instance has already timed out on the same stimulus
        chk("to_err_early", {31'd0, t_mem_err}, 32'd1);

        // ---- reset pulse (abandons nothing pending here) ----
        rst_n = 0;
        #2;
        chk_to("to_rst", 7'b0000_111);
        step();
        rst_n = 1;
        #2;
        chk("to_err_clr", {31'd0, t_mem_err}, 32'd0);

        // ---- timeout on TIMEOUT=4 ----
        step();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk_to($sformatf("to_stall%0d", i), 7'b1111_001);
            chk($sformatf("to_noerr%0d", i), {31'd0, t_mem_err}, 32'd0);
            step();
        end
        #2;
        chk("to_err", {31'd0, t_mem_err}, 32'd1);
        chk_to("to_hold", 7'b1111_001);
        step();
        MemReadyM = 1;
        #2;
        chk("to_err_sticky", {31'd0, t_mem_err}, 32'd1);
        chk_to("to_hold_rdy", 7'b1111_001);
        // TIMEOUT=8 instance released by the ready input
        chk_sf("dut_release", 7'b0000_000);
        chk("dut_noerr", {31'd0, mem_err}, 32'd0);

        // ---- reset mid-wait on u_dut, error exit on u_to ----
        step();
        MemReadyM = 0;
        step();
        rst_n = 0;
        #2;
        chk_sf("rst_mid", 7'b0000_111);
        step();
        rst_n = 1;
        idle();
        #2;
        chk("to_err_rst", {31'd0, t_mem_err}, 32'd0);
        chk_to("to_run", 7'b0000_000);
        chk_sf("dut_run", 7'b0000_000);

        // ---- zero-wait accesses ----
        for (int i = 0; i < 10; i++) begin
            step();
            MemReqM = 1; MemReadyM = 1;
            #2;
            chk_sf($sformatf("zw%0d", i), 7'b0000_000);
        end
        step();
        idle();
        #2;
        chk_to("zw_to_run", 7'b0000_000);
`ifdef HAZARD_PERF_EN
        chk("zw_perf", p_ms, 32'd0);
        chk("zw_perf_to", tp_ms, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
